maxnet_operand_loader: RTL and testbench

- Upstream front-end for the Maxnet_model core.
- Accepts a serial stream of IEEE-754 single-precision activations over a valid/ready handshake and buffers four of them.
- Drives the core's a1..a4/eps operands and a one-cycle start pulse.
- Holds the operands stable until the core's finish, then captures out/overflow into a result register offered on a second valid/ready port.
- Replaces the bench's hand-driven start/a1..a4 in the system path.

---
 rtl/maxnet_pkg.sv | 7 +
 rtl/maxnet_result_reg.sv | 33 +++
 rtl/maxnet_operand_loader.sv | 122 ++++++++++++
 tb/tb_maxnet_operand_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/maxnet_pkg.sv
// maxnet_pkg: shared operand width, loader state encoding and IEEE-754 constants
package maxnet_pkg;
    localparam int DATA_W = 32;
    localparam logic [DATA_W-1:0] DEFAULT_EPS = 32'hBE4CCCCD;
    localparam logic [DATA_W-1:0] QNAN = 32'h7FC00000;
    typedef enum logic [1:0] {ST_FILL, ST_LAUNCH, ST_WAIT, ST_RESULT} loader_state_t;
endpackage

// File: rtl/maxnet_result_reg.sv
// maxnet_result_reg: result holding register with a valid/ready output handshake
module maxnet_result_reg
    import maxnet_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_overflow,
    input  logic              load_timeout,
    input  logic              res_ready,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              res_overflow,
    output logic              res_timeout
);
    // capture a result when empty, release it on the consumer handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_overflow <= 1'b0;
            res_timeout  <= 1'b0;
        end else if (load && !res_valid) begin
            res_valid    <= 1'b1;
            res_data     <= load_data;
            res_overflow <= load_overflow;
            res_timeout  <= load_timeout;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/maxnet_operand_loader.sv
// maxnet_operand_loader: buffers four activations, launches the Maxnet core and returns its result; optional watchdog via MAXNET_LOADER_WATCHDOG_EN
module maxnet_operand_loader
    import maxnet_pkg::*;
#(
    parameter logic [DATA_W-1:0] DEFAULT_EPS = maxnet_pkg::DEFAULT_EPS,
    parameter int unsigned       WDOG_CYCLES = 200000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              cfg_eps_sel,
    input  logic [DATA_W-1:0] cfg_eps,
    output logic              mx_start,
    output logic [DATA_W-1:0] mx_eps,
    output logic [DATA_W-1:0] mx_a1,
    output logic [DATA_W-1:0] mx_a2,
    output logic [DATA_W-1:0] mx_a3,
    output logic [DATA_W-1:0] mx_a4,
    input  logic              mx_finish,
    input  logic              mx_overflow,
    input  logic [DATA_W-1:0] mx_out,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              res_overflow,
    output logic              res_timeout,
    input  logic              res_ready
);
    loader_state_t     state, state_next;
    logic [1:0]        cnt;
    logic [DATA_W-1:0] a [4];
    logic [DATA_W-1:0] eps_q;
    logic              armed;
    logic              fire;
    logic              capture;
    logic              timeout;
    logic              load;

    assign fire    = in_valid && in_ready;
    assign capture = state == ST_WAIT && armed && mx_finish;
    assign load    = capture || timeout;
    assign mx_a1   = a[0];
    assign mx_a2   = a[1];
    assign mx_a3   = a[2];
    assign mx_a4   = a[3];
    assign mx_eps  = eps_q;

`ifdef MAXNET_LOADER_WATCHDOG_EN
    logic [31:0] wdog;

    // count WAIT cycles of the current run; a finish on the limit cycle still wins
    always_ff @(posedge clk) begin
        if (rst || state == ST_LAUNCH)
            wdog <= '0;
        else if (state == ST_WAIT)
            wdog <= wdog + 32'd1;
    end

    assign timeout = state == ST_WAIT && !capture && wdog == 32'(WDOG_CYCLES - 1);
`else
    assign timeout = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_FILL;
        else
            state <= state_next;
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_FILL:   state_next = (fire && cnt == 2'd3) ? ST_LAUNCH : ST_FILL;
            ST_LAUNCH: state_next = ST_WAIT;
            ST_WAIT:   state_next = load ? ST_RESULT : ST_WAIT;
            ST_RESULT: state_next = res_ready ? ST_FILL : ST_RESULT;
            default:   state_next = ST_FILL;
        endcase
    end

    // handshake and start pulse decoded from the registered state
    always_comb begin
        in_ready = state == ST_FILL;
        mx_start = state == ST_LAUNCH;
    end

    // operand buffer, eps latch and stale-finish guard (armed only after the first WAIT cycle)
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= 2'd0;
            a     <= '{default: '0};
            eps_q <= DEFAULT_EPS;
            armed <= 1'b0;
        end else begin
            armed <= state == ST_WAIT;
            if (fire) begin
                a[cnt] <= in_data;
                cnt    <= cnt + 2'd1;
                if (cnt == 2'd3)
                    eps_q <= cfg_eps_sel ? cfg_eps : DEFAULT_EPS;
            end
        end
    end

    maxnet_result_reg u_result (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .load_data    (capture ? mx_out : QNAN),
        .load_overflow(capture && mx_overflow),
        .load_timeout (!capture),
        .res_ready    (res_ready),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .res_overflow (res_overflow),
        .res_timeout  (res_timeout)
    );
endmodule

// File: tb/tb_maxnet_operand_loader.sv
// tb_maxnet_operand_loader: randomized self-checking bench with an in-bench core stub and run-level reference model
module tb_maxnet_operand_loader;
    localparam logic [31:0] DEF  = 32'hBE4CCCCD;
    localparam logic [31:0] NAN  = 32'h7FC00000;
    localparam logic [31:0] JUNK = 32'hDEADBEEF;
`ifdef MAXNET_LOADER_WATCHDOG_EN
    localparam int TMO = 49;
`else
    localparam int TMO = 1000000;
`endif

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, cfg_eps_sel, mx_start, mx_finish, mx_overflow;
    logic        res_valid, res_overflow, res_timeout, res_ready;
    logic [31:0] in_data, cfg_eps, mx_eps, mx_a1, mx_a2, mx_a3, mx_a4, mx_out, res_data;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] words [4];
    logic [31:0] res_word;
    logic        res_ovf;

    always #5 clk = ~clk;

    maxnet_operand_loader #(.WDOG_CYCLES(50)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .cfg_eps_sel(cfg_eps_sel), .cfg_eps(cfg_eps), .mx_start(mx_start), .mx_eps(mx_eps),
        .mx_a1(mx_a1), .mx_a2(mx_a2), .mx_a3(mx_a3), .mx_a4(mx_a4),
        .mx_finish(mx_finish), .mx_overflow(mx_overflow), .mx_out(mx_out),
        .res_valid(res_valid), .res_data(res_data), .res_overflow(res_overflow),
        .res_timeout(res_timeout), .res_ready(res_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks;
        check("rst_a1", mx_a1, 0);
        check("rst_a2", mx_a2, 0);
        check("rst_a3", mx_a3, 0);
        check("rst_a4", mx_a4, 0);
        check("rst_eps", mx_eps, DEF);
        check("rst_start", {31'd0, mx_start}, 0);
        check("rst_res_valid", {31'd0, res_valid}, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_ovf", {31'd0, res_overflow}, 0);
        check("rst_res_tmo", {31'd0, res_timeout}, 0);
        check("rst_in_ready", {31'd0, in_ready}, 1);
    endtask

    task automatic pulse_reset;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick;
            in_valid = 1'b1;
            in_data = words[i];
            check("fill_in_ready", {31'd0, in_ready}, 1);
            tick;
        end
        in_valid = 1'b0;
    endtask

    task automatic rand_words;
        for (int i = 0; i < 4; i++) words[i] = $urandom;
    endtask

    // d: WAIT cycle index from which the stub finishes; stale: finish also high in LAUNCH and WAIT cycle 0
    task automatic run_one(input int d, input bit stale, input bit never, input int hold);
        logic [31:0] eps_exp;
        int          wd, end_k;
        bit          tmo;
        fill(4);
        eps_exp = cfg_eps_sel ? cfg_eps : DEF;
        in_valid = hold > 0;
        in_data = JUNK;
        check("start_high", {31'd0, mx_start}, 1);
        check("launch_in_ready", {31'd0, in_ready}, 0);
        check("a1", mx_a1, words[0]);
        check("a2", mx_a2, words[1]);
        check("a3", mx_a3, words[2]);
        check("a4", mx_a4, words[3]);
        check("eps", mx_eps, eps_exp);
        mx_finish = stale;
        mx_out = JUNK;
        mx_overflow = stale;
        tick;
        check("start_once", {31'd0, mx_start}, 0);
        wd = (d < 1) ? 1 : d;
        end_k = never ? TMO : (wd < TMO ? wd : TMO);
        tmo = never || wd > TMO;
        if (end_k > 150) begin
            mx_finish = 1'b0;
            for (int k = 0; k < 100; k++) begin
                check("no_result", {31'd0, res_valid}, 0);
                tick;
            end
            pulse_reset;
            reset_checks;
            return;
        end
        for (int k = 0; k <= end_k; k++) begin
            check("res_valid_early", {31'd0, res_valid}, 0);
            mx_finish = (!never && k >= d) || (stale && k == 0);
            mx_out = (!never && k >= d) ? res_word : JUNK;
            mx_overflow = (!never && k >= d) ? res_ovf : stale;
            tick;
        end
        mx_finish = 1'b0;
        mx_out = JUNK;
        mx_overflow = 1'b0;
        check("res_valid", {31'd0, res_valid}, 1);
        check("res_data", res_data, tmo ? NAN : res_word);
        check("res_ovf", {31'd0, res_overflow}, {31'd0, tmo ? 1'b0 : res_ovf});
        check("res_tmo", {31'd0, res_timeout}, {31'd0, tmo});
        check("hold_a1", mx_a1, words[0]);
        check("hold_a4", mx_a4, words[3]);
        check("hold_eps", mx_eps, eps_exp);
        res_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            check("bp_in_ready", {31'd0, in_ready}, 0);
            check("bp_res_valid", {31'd0, res_valid}, 1);
            check("bp_res_data", res_data, tmo ? NAN : res_word);
            tick;
        end
        res_ready = 1'b1;
        in_valid = 1'b0;
        tick;
        res_ready = 1'b0;
        check("drain_res_valid", {31'd0, res_valid}, 0);
        check("drain_in_ready", {31'd0, in_ready}, 1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        cfg_eps_sel = 1'b0;
        cfg_eps = '0;
        mx_finish = 1'b0;
        mx_overflow = 1'b0;
        mx_out = '0;
        res_ready = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        reset_checks;

        words = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'h40400000};
        res_word = 32'h40400000;
        res_ovf = 1'b0;
        run_one(10, 1'b0, 1'b0, 0);

        rand_words;
        res_word = $urandom;
        run_one(3, 1'b0, 1'b0, 20);
        rand_words;
        res_word = $urandom;
        run_one(5, 1'b0, 1'b0, 0);

        rand_words;
        res_word = $urandom;
        run_one(0, 1'b1, 1'b0, 0);
        rand_words;
        run_one(1, 1'b1, 1'b0, 2);

        rand_words;
        fill(4);
        tick;
        pulse_reset;
        reset_checks;
        rand_words;
        fill(2);
        pulse_reset;
        reset_checks;
        rand_words;
        res_word = $urandom;
        run_one(4, 1'b0, 1'b0, 0);

        cfg_eps_sel = 1'b1;
        cfg_eps = 32'hBDCCCCCD;
        res_ovf = 1'b1;
        rand_words;
        run_one(7, 1'b0, 1'b0, 0);

        repeat (8) begin
            cfg_eps_sel = 1'($urandom);
            cfg_eps = $urandom;
            res_ovf = 1'($urandom);
            res_word = $urandom;
            rand_words;
            run_one(int'($urandom_range(0, 20)), 1'($urandom), 1'b0, int'($urandom_range(0, 5)));
        end

        cfg_eps_sel = 1'b0;
        rand_words;
        run_one(0, 1'b0, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
